// File: rtl/tank_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tank_access_arbiter
// Description : Round-robin sequencer sharing one bounded volume counter
//               between NREQ fill/drain requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_access_arbiter #(
    parameter int NREQ  = 4,
    parameter int CAP   = 400000,
    parameter int CBITS = 19,
    parameter int IDXW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    output logic [NREQ-1:0]   gnt,
    output logic [IDXW-1:0]   gnt_idx,
    output logic [CBITS-1:0]  vol,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              done
);

    localparam int               c_SW       = IDXW + 1;
    localparam logic [c_SW-1:0]  c_NREQ     = c_SW'(NREQ);
    localparam logic [CBITS-1:0] c_CAP      = CBITS'(CAP);
    localparam logic [IDXW-1:0]  c_LAST_IDX = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0]  c_ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [IDXW-1:0]   r_gnt_idx;
    logic [IDXW-1:0]   w_idx_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    logic [CBITS-1:0]  r_vol;
    logic [CBITS-1:0]  w_vol_nxt;
    logic [CBITS-1:0]  w_vol_inc;
    logic [CBITS-1:0]  w_vol_dec;
    logic              r_full;
    logic              r_empty;
    logic              r_done;
    logic              w_done_nxt;

    logic [NREQ-1:0]   w_elig;
    logic              w_pick_vld;
    logic [IDXW-1:0]   w_pick;
    logic [c_SW-1:0]   w_cand;

    assign w_elig    = req & ((dir & {NREQ{~r_full}}) | (~dir & {NREQ{~r_empty}}));
    assign w_vol_inc = r_vol + CBITS'(1);
    assign w_vol_dec = r_vol - CBITS'(1);

    // First eligible index after the last grantee, wrapping modulo NREQ.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_gnt_idx} + c_SW'(i + 1);
            if (w_cand >= c_NREQ) begin
                w_cand = w_cand - c_NREQ;
            end
            if (!w_pick_vld && w_elig[w_cand[IDXW-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_dir_nxt   = r_dir;
        w_vol_nxt   = r_vol;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_SERVE;
                    w_gnt_nxt   = c_ONE << w_pick;
                    w_idx_nxt   = w_pick;
                    w_dir_nxt   = dir[w_pick];
                end
            end
            ST_SERVE: begin
                if (!req[r_gnt_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end else begin
                    w_vol_nxt = r_dir ? w_vol_inc : w_vol_dec;
                    // Boundary ends the grant on the same edge that reaches it.
                    if ((r_dir && (w_vol_inc == c_CAP)) || (!r_dir && (w_vol_dec == '0))) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= c_LAST_IDX;
            r_dir     <= 1'b0;
            r_vol     <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_dir     <= w_dir_nxt;
            r_vol     <= w_vol_nxt;
            r_full    <= (w_vol_nxt == c_CAP);
            r_empty   <= (w_vol_nxt == '0);
            r_done    <= w_done_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign vol     = r_vol;
    assign full    = r_full;
    assign empty   = r_empty;
    assign busy    = (r_state == ST_SERVE);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tank_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_access_arbiter
// Description : Directed self-checking bench; a CAP=5 and a CAP=100 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_access_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_s, dir_s, gnt_s;
    logic [1:0] idx_s;
    logic [2:0] vol_s;
    logic       full_s, empty_s, busy_s, done_s;
    logic [3:0] req_h, dir_h, gnt_h;
    logic [1:0] idx_h;
    logic [6:0] vol_h;
    logic       full_h, empty_h, busy_h, done_h;

    int errors = 0;
    int checks = 0;

    tank_access_arbiter #(.NREQ(4), .CAP(5), .CBITS(3), .IDXW(2)) u_small (
        .clk(clk), .rst(rst), .req(req_s), .dir(dir_s), .gnt(gnt_s),
        .gnt_idx(idx_s), .vol(vol_s), .full(full_s), .empty(empty_s),
        .busy(busy_s), .done(done_s)
    );

    tank_access_arbiter #(.NREQ(4), .CAP(100), .CBITS(7), .IDXW(2)) u_big (
        .clk(clk), .rst(rst), .req(req_h), .dir(dir_h), .gnt(gnt_h),
        .gnt_idx(idx_h), .vol(vol_h), .full(full_h), .empty(empty_h),
        .busy(busy_h), .done(done_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_small(input string tag, input logic [3:0] g, input logic [2:0] v,
                             input logic f, input logic e, input logic b, input logic d);
        chk({tag, ".gnt"},   32'(gnt_s),   32'(g));
        chk({tag, ".vol"},   32'(vol_s),   32'(v));
        chk({tag, ".full"},  32'(full_s),  32'(f));
        chk({tag, ".empty"}, 32'(empty_s), 32'(e));
        chk({tag, ".busy"},  32'(busy_s),  32'(b));
        chk({tag, ".done"},  32'(done_s),  32'(d));
    endtask

    initial begin
        logic [1:0] rr_order [5];
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b0;
        req_s = '0; dir_s = '0; req_h = '0; dir_h = '0;
        tick(); tick();

        // Reset state
        chk_small("reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.idx", 32'(idx_s), 32'd3);
        rst = 1'b1;

        // Single fill by requester 0
        req_s = 4'b0001; dir_s = 4'b0001;
        tick();
        chk_small("fill.grant", 4'b0001, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fill.idx", 32'(idx_s), 32'd0);
        for (int v = 1; v <= 4; v++) begin
            tick();
            chk_small("fill.step", 4'b0001, 3'(v), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_small("fill.end", 4'b0000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_small("fill.blocked", 4'b0000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Drain from full by requester 2 (requester 0 fill still held but ineligible)
        req_s = 4'b0101; dir_s = 4'b0001;
        tick();
        chk_small("drain.grant", 4'b0100, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("drain.idx", 32'(idx_s), 32'd2);
        for (int v = 4; v >= 1; v--) begin
            tick();
            chk_small("drain.step", 4'b0100, 3'(v), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_small("drain.end", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        req_s = 4'b0000;
        tick();
        chk_small("drain.idle", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Early release by requester 1 after two increments
        req_s = 4'b0010; dir_s = 4'b0010;
        tick();
        chk_small("early.grant", 4'b0010, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk_small("early.two", 4'b0010, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        req_s = 4'b0000;
        tick();
        chk_small("early.drop", 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant at vol=3
        req_s = 4'b0010;
        tick();
        chk_small("arst.grant", 4'b0010, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_small("arst.vol3", 4'b0010, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_small("arst.now", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("arst.idx", 32'(idx_s), 32'd3);
        req_s = 4'b0000;
        tick();
        rst = 1'b1;

        // Blocked drain at vol=0, then a fill unblocks it
        req_s = 4'b1000; dir_s = 4'b0000;
        tick(); tick();
        chk_small("block.none", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        req_s = 4'b1010; dir_s = 4'b0010;
        tick();
        chk_small("block.fill", 4'b0010, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_small("block.inc", 4'b0010, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        req_s = 4'b1000;
        tick();
        chk_small("block.gap", 4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_small("block.drain", 4'b1000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("block.idx", 32'(idx_s), 32'd3);
        tick();
        chk_small("block.empty", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        req_s = 4'b0000;

        // Round robin on the CAP=100 instance: each grantee drops after one increment
        req_h = 4'b1111; dir_h = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr.gnt", 32'(gnt_h), 32'(4'b0001 << rr_order[k]));
            chk("rr.idx", 32'(idx_h), 32'(rr_order[k]));
            tick();
            chk("rr.vol", 32'(vol_h), 32'(k + 1));
            req_h[rr_order[k]] = 1'b0;
            tick();
            chk("rr.gap", 32'(gnt_h), 32'd0);
            chk("rr.busy", 32'(busy_h), 32'd0);
            req_h = 4'b1111;
        end
        chk("rr.round", 32'(vol_h), 32'd5);
        chk("rr.done", 32'(done_h), 32'd0);
        req_h = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tank_access_arbiter.md
Name: tank_access_arbiter

Overview:
- Shares one bounded volume counter (the tank) between NREQ requesters. Each requester either fills (load) or drains (store) the tank.
- Round-robin arbitration grants one requester at a time. The granted requester moves the volume by one unit per cycle.
- Tracks the full and empty boundaries, blocks requests that cannot be served, and reports completion.
- Sits in front of the load/store volume datapath as its sequencer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CAP, 400000, tank capacity; volume range is 0..CAP.
- CBITS, 19, volume width; must satisfy 2^CBITS > CAP.
- IDXW, 2, grant-index width; must satisfy 2^IDXW >= NREQ.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- dir  in  NREQ  per-requester direction: 1 = fill (load), 0 = drain (store).
- gnt  out  NREQ  one-hot grant; all zeros when idle.
- gnt_idx  out  IDXW  index of the current or last grantee.
- vol  out  CBITS  current tank volume.
- full  out  1  vol == CAP.
- empty  out  1  vol == 0.
- busy  out  1  in SERVE state.
- done  out  1  one-cycle pulse when a grant ends because a boundary was reached.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = IDLE, gnt = 0, gnt_idx = NREQ-1, vol = 0;
  - full = 0, empty = 1, busy = 0, done = 0.
  - Reset is released synchronously by the integrator.
- Reset mid-SERVE aborts the grant immediately; vol returns to 0.
- Eligibility (combinational):
  - requester i is eligible iff req[i] && ((dir[i] && !full) || (!dir[i] && !empty)).
- IDLE:
  - If any requester is eligible, pick the first eligible index scanning gnt_idx+1, gnt_idx+2, ... with wrap modulo NREQ.
  - At the next edge: gnt[k] = 1, gnt_idx = k, the direction dir[k] is latched, busy = 1, state goes to SERVE.
  - Otherwise stay in IDLE.
- SERVE, evaluated each edge with grantee g and latched direction d:
  - req[g] == 0: gnt = 0, busy = 0, vol unchanged, no done, state goes to IDLE.
  - Otherwise vol = vol + 1 if d = 1, else vol - 1.
  - If the new vol equals CAP (fill) or 0 (drain): at that same edge gnt = 0, busy = 0, done = 1, state goes to IDLE.
  - Otherwise stay in SERVE.
- Changes to dir[g] during SERVE are ignored.
- Requests from non-granted requesters are ignored during SERVE; there is no preemption.
- Every grant is followed by at least one IDLE cycle. No back-to-back grants.
- Latency:
  - req rising in IDLE (eligible) gives gnt on the next edge.
  - The first vol change occurs on the edge after gnt rises.
- Outputs are registered:
  - full and empty are updated on the same edge as vol;
  - done is high for exactly one cycle, otherwise 0.
- Invariants:
  - vol never exceeds CAP and never underflows.
  - gnt is one-hot or zero.
  - busy == (gnt != 0).
  - A granted requester holding req reaches a boundary within CAP cycles (liveness).
- Fairness: while held eligible, a requester is granted within NREQ-1 intervening grants.

Test Plan:
- Reset and single fill: CAP=5, CBITS=3. Release reset, req[0]=1, dir[0]=1, held.
  -> gnt=0001 one cycle later; vol steps 1,2,3,4,5; done pulses on the edge vol=5; full=1; gnt=0; req[0] is then ineligible.
- Drain from full: after the fill above, req[2]=1, dir[2]=0.
  -> gnt=0100; vol steps 4..0; done pulse; empty=1; total of 5 SERVE cycles.
- Early release: CAP=5. req[1] fill, drop req[1] after 2 increments.
  -> vol=2, gnt=0, done stays 0, full=0, empty=0.
- Round robin: CAP=100. All four req fill, each dropped after 1 increment then reasserted.
  -> grant order 0,1,2,3,0.
  -> An IDLE cycle occurs between each grant; vol increments by 4 per round.
- Blocked requests: vol=0. Only req[3] drain asserted.
  -> no grant.
  -> Then req[1] fill is added: gnt=0010.
  -> After 1 increment, req[1] drops: next grant goes to 3 (drain now eligible).
- Async reset mid-SERVE: assert rst=0 between edges while vol=3.
  -> gnt=0, vol=0, empty=1 immediately, without waiting for the next clock edge.
